iq_upmixer: RTL and testbench

//  Transmit-side fs/4 quadrature up-mixer, the TX counterpart of the decoder's cos/sin LO.

---
 rtl/iq_upmixer.sv | 200 ++++++++++++++++++++
 tb/tb_iq_upmixer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_upmixer.sv
// -----------------------------------------------------------------------------
// iq_upmixer
//   Transmit-side fs/4 quadrature up-mixer. Signed baseband I/Q samples are
//   queued in a small FIFO. One sample is taken every SAMPLE_PERIOD clocks and
//   mixed onto a quarter-rate carrier whose cos/sin take the values
//   +LO_AMP, 0 and -LO_AMP. The result is one real IF sample per slot.
//
//   Ports
//     i_clk        clock
//     i_rst_n      asynchronous active-low reset
//     i_en         mixer enable; low = idle, flush FIFO, clear phase and o_if
//     i_i, i_q     signed in-phase / quadrature sample (IQ_W bits)
//     i_valid      sample valid; accepted when o_ready is high and i_en is high
//     o_ready      FIFO not full (registered)
//     o_if         signed mixed IF sample (IQ_W+4 bits), held between pulses
//     o_if_valid   one-cycle pulse per new o_if
//     o_underflow  one-cycle pulse: the sample slot found the FIFO empty
//     o_phase      carrier phase index used for the last emitted sample
// -----------------------------------------------------------------------------
module iq_upmixer #(
  parameter int IQ_W          = 8,
  parameter int LO_AMP        = 7,
  parameter int SAMPLE_PERIOD = 5,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic signed [IQ_W-1:0] i_i,
  input  logic signed [IQ_W-1:0] i_q,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic signed [IQ_W+3:0] o_if,
  output logic                   o_if_valid,
  output logic                   o_underflow,
  output logic [1:0]             o_phase
);

  localparam int OUT_W = IQ_W + 4;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(SAMPLE_PERIOD);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  localparam logic signed [OUT_W-1:0] C_AMP     = OUT_W'(LO_AMP);
  localparam logic [CNT_W-1:0]        C_CNT_END = CNT_W'(SAMPLE_PERIOD - 2);
  localparam logic [PTR_W:0]          C_FULL    = (PTR_W + 1)'(FIFO_DEPTH);

  // Control and output registers
  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [1:0]             r_phase;
  logic signed [OUT_W-1:0] r_if;
  logic                   r_if_valid;
  logic                   r_underflow;
  logic [1:0]             r_out_phase;
  logic                   r_ready;

  // FIFO storage and bookkeeping
  logic signed [IQ_W-1:0] r_mem_i [FIFO_DEPTH];
  logic signed [IQ_W-1:0] r_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W:0]         r_count;

  // Combinational helpers
  logic                    w_push;
  logic                    w_pop;
  logic                    w_have;
  logic                    w_emit;
  logic signed [IQ_W-1:0]  w_head_i;
  logic signed [IQ_W-1:0]  w_head_q;
  logic signed [OUT_W-1:0] w_i_ext;
  logic signed [OUT_W-1:0] w_q_ext;
  logic signed [OUT_W-1:0] w_src;
  logic signed [OUT_W-1:0] w_y;
  logic [PTR_W:0]          w_count_nxt;
  logic                    w_ready_nxt;

  assign o_ready     = r_ready;
  assign o_if        = r_if;
  assign o_if_valid  = r_if_valid;
  assign o_underflow = r_underflow;
  assign o_phase     = r_out_phase;

  // FIFO handshake: pushes are gated by the registered ready, pops by the emit slot
  always_comb begin
    w_have = (r_count != {(PTR_W + 1){1'b0}});
    w_emit = (r_state == S_EMIT) && i_en;
    w_push = i_valid && r_ready && i_en;
    w_pop  = w_emit && w_have;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (PTR_W + 1)'(1);
      2'b01:   w_count_nxt = r_count - (PTR_W + 1)'(1);
      default: w_count_nxt = r_count;
    endcase
    w_ready_nxt = (w_count_nxt != C_FULL);
  end

  // Mixer: cos/sin are 0 or +/-A, so each phase reduces to a signed scale of I or Q
  always_comb begin
    w_head_i = r_mem_i[r_rd_ptr];
    w_head_q = r_mem_q[r_rd_ptr];
    w_i_ext  = {{4{w_head_i[IQ_W-1]}}, w_head_i};
    w_q_ext  = {{4{w_head_q[IQ_W-1]}}, w_head_q};
    case (r_phase)
      2'd0:    w_src = -w_q_ext;
      2'd1:    w_src = w_i_ext;
      2'd2:    w_src = w_q_ext;
      2'd3:    w_src = -w_i_ext;
      default: w_src = {OUT_W{1'b0}};
    endcase
    if (w_have) begin
      w_y = w_src * C_AMP;
    end else begin
      // underflow slot mixes a zero sample
      w_y = {OUT_W{1'b0}};
    end
  end

  // FIFO data storage; contents need no reset since the count gates every read
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_i[r_wr_ptr] <= i_i;
      r_mem_q[r_wr_ptr] <= i_q;
    end
  end

  // Slot timing FSM, carrier phase, output registers and FIFO pointers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_phase     <= 2'd0;
      r_if        <= {OUT_W{1'b0}};
      r_if_valid  <= 1'b0;
      r_underflow <= 1'b0;
      r_out_phase <= 2'd0;
      r_ready     <= 1'b1;
      r_wr_ptr    <= {PTR_W{1'b0}};
      r_rd_ptr    <= {PTR_W{1'b0}};
      r_count     <= {(PTR_W + 1){1'b0}};
    end else if (!i_en) begin
      // disable flushes everything and restarts the carrier at phase 0
      r_state     <= S_IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_phase     <= 2'd0;
      r_if        <= {OUT_W{1'b0}};
      r_if_valid  <= 1'b0;
      r_underflow <= 1'b0;
      r_out_phase <= 2'd0;
      r_ready     <= 1'b1;
      r_wr_ptr    <= {PTR_W{1'b0}};
      r_rd_ptr    <= {PTR_W{1'b0}};
      r_count     <= {(PTR_W + 1){1'b0}};
    end else begin
      r_if_valid  <= 1'b0;
      r_underflow <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state <= S_WAIT;
          r_cnt   <= {CNT_W{1'b0}};
        end
        S_WAIT: begin
          if (r_cnt == C_CNT_END) begin
            r_state <= S_EMIT;
            r_cnt   <= {CNT_W{1'b0}};
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_EMIT: begin
          r_state     <= S_WAIT;
          r_cnt       <= {CNT_W{1'b0}};
          r_if        <= w_y;
          r_out_phase <= r_phase;
          r_if_valid  <= 1'b1;
          r_underflow <= !w_have;
          // the carrier keeps running even when the slot underflows
          r_phase     <= r_phase + 2'd1;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= {CNT_W{1'b0}};
        end
      endcase
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
      r_ready <= w_ready_nxt;
    end
  end

endmodule

// File: tb/tb_iq_upmixer.sv
module tb_iq_upmixer;

  localparam int SP    = 5;
  localparam int DEPTH = 4;
  localparam int AMP   = 7;

  logic              clk;
  logic              rst_n;
  logic              i_en;
  logic signed [7:0] i_i;
  logic signed [7:0] i_q;
  logic              i_valid;
  logic              o_ready;
  logic signed [11:0] o_if;
  logic              o_if_valid;
  logic              o_underflow;
  logic [1:0]        o_phase;

  iq_upmixer #(
    .IQ_W(8), .LO_AMP(AMP), .SAMPLE_PERIOD(SP), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(i_en), .i_i(i_i), .i_q(i_q),
    .i_valid(i_valid), .o_ready(o_ready), .o_if(o_if), .o_if_valid(o_if_valid),
    .o_underflow(o_underflow), .o_phase(o_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // behavioural reference: time-slot model with a sample queue
  int mq_i[$];
  int mq_q[$];
  int m_k;       // clocks since enable (-1 when idle)
  int m_nemit;   // emissions since enable
  int m_if, m_v, m_uf, m_ph, m_rdy;

  typedef struct {
    logic en; logic valid; int i; int q;
    int e_if; int e_v; int e_uf; int e_ph; int e_rdy;
  } vec_t;
  vec_t tbl[26];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int carrier(input int p);
    case (p % 4)
      0: return 0;
      1: return AMP;
      2: return 0;
      default: return -AMP;
    endcase
  endfunction

  function automatic int mix(input int p, input int iv, input int qv);
    return iv * carrier(p) - qv * carrier(p + 1);
  endfunction

  task automatic m_reset();
    mq_i.delete(); mq_q.delete();
    m_k = -1; m_nemit = 0;
    m_if = 0; m_v = 0; m_uf = 0; m_ph = 0; m_rdy = 1;
  endtask

  task automatic m_edge(input logic en, input logic valid, input int iv, input int qv);
    bit push;
    if (!en) begin
      m_reset();
    end else begin
      push = valid && (m_rdy == 1);
      m_k++;
      m_v = 0; m_uf = 0;
      if (m_k > 0 && (m_k % SP) == 0) begin
        m_ph = m_nemit % 4;
        if (mq_i.size() > 0) begin
          m_if = mix(m_ph, mq_i.pop_front(), mq_q.pop_front());
        end else begin
          m_if = 0; m_uf = 1;
        end
        m_v = 1;
        m_nemit++;
      end
      if (push) begin
        mq_i.push_back(iv); mq_q.push_back(qv);
      end
      m_rdy = (mq_i.size() < DEPTH) ? 1 : 0;
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, " o_if"}, int'(o_if), m_if);
    chk({tag, " o_if_valid"}, int'(o_if_valid), m_v);
    chk({tag, " o_underflow"}, int'(o_underflow), m_uf);
    chk({tag, " o_phase"}, int'(o_phase), m_ph);
    chk({tag, " o_ready"}, int'(o_ready), m_rdy);
  endtask

  task automatic step(input string tag, input logic en, input logic valid,
                      input int iv, input int qv);
    i_en = en; i_valid = valid; i_i = 8'(iv); i_q = 8'(qv);
    @(posedge clk);
    m_edge(en, valid, iv, qv);
    #1;
    cmp_model(tag);
  endtask

  int pend_i, pend_q;
  logic pend_v;
  logic en_r;

  initial begin
    rst_n = 1'b0; i_en = 1'b0; i_valid = 1'b0; i_i = 8'sd0; i_q = 8'sd0;
    m_reset();

    // table for continuous I=10,Q=3 stream, expectations derived by hand
    for (int k = 0; k < 26; k++) begin
      int p;
      tbl[k].en = 1'b1; tbl[k].valid = 1'b1; tbl[k].i = 10; tbl[k].q = 3;
      tbl[k].e_v  = (k > 0 && k % 5 == 0) ? 1 : 0;
      tbl[k].e_uf = 0;
      p = (k < 5) ? 0 : ((k / 5) - 1) % 4;
      tbl[k].e_ph = p;
      if (k < 5) tbl[k].e_if = 0;
      else case (p)
        0: tbl[k].e_if = -21;
        1: tbl[k].e_if = 70;
        2: tbl[k].e_if = 21;
        default: tbl[k].e_if = -70;
      endcase
      tbl[k].e_rdy = (k < 3 || k % 5 == 0) ? 1 : 0;
    end

    // 1: reset values, and nothing happens while disabled
    #12;
    chk("rst o_if", int'(o_if), 0);
    chk("rst o_if_valid", int'(o_if_valid), 0);
    chk("rst o_underflow", int'(o_underflow), 0);
    chk("rst o_phase", int'(o_phase), 0);
    chk("rst o_ready", int'(o_ready), 1);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step("idle", 1'b0, 1'b1, 55, -40);

    // 2: table-driven continuous stream
    for (int k = 0; k < 26; k++) begin
      step("stream", tbl[k].en, tbl[k].valid, tbl[k].i, tbl[k].q);
      chk("tbl o_if", int'(o_if), tbl[k].e_if);
      chk("tbl o_if_valid", int'(o_if_valid), tbl[k].e_v);
      chk("tbl o_underflow", int'(o_underflow), tbl[k].e_uf);
      chk("tbl o_phase", int'(o_phase), tbl[k].e_ph);
      chk("tbl o_ready", int'(o_ready), tbl[k].e_rdy);
    end

    // 3: enabled with no input -> underflow on every slot, phase still steps
    step("flush", 1'b0, 1'b0, 0, 0);
    for (int k = 0; k <= 20; k++) begin
      step("empty", 1'b1, 1'b0, 0, 0);
      if (k > 0 && k % 5 == 0) begin
        chk("empty uf", int'(o_underflow), 1);
        chk("empty phase", int'(o_phase), (k / 5 - 1) % 4);
      end
    end

    // 4: four pushes back-to-back, ready drop/return and order
    step("flush", 1'b0, 1'b0, 0, 0);
    for (int k = 0; k <= 20; k++) begin
      step("order", 1'b1, (k < 4), k + 1, -(k + 1));
      if (k == 3) chk("full ready", int'(o_ready), 0);
      if (k == 4) chk("full ready hold", int'(o_ready), 0);
      if (k == 5) begin chk("ready back", int'(o_ready), 1); chk("ord s1", int'(o_if), 7); end
      if (k == 10) chk("ord s2", int'(o_if), 14);
      if (k == 15) chk("ord s3", int'(o_if), -21);
      if (k == 20) chk("ord s4", int'(o_if), -28);
    end

    // 5: extremes
    step("flush", 1'b0, 1'b0, 0, 0);
    for (int k = 0; k <= 20; k++) begin
      int iv, qv;
      iv = 0; qv = 0;
      if (k == 0) qv = -128;
      if (k == 1) iv = -128;
      if (k == 2) qv = 127;
      step("extreme", 1'b1, (k < 3), iv, qv);
      if (k == 5) chk("ext q-128 p0", int'(o_if), 896);
      if (k == 10) chk("ext i-128 p1", int'(o_if), -896);
      if (k == 15) chk("ext q127 p2", int'(o_if), 889);
      if (k == 20) chk("ext uf p3", int'(o_underflow), 1);
    end

    // 6a: drop enable mid-WAIT with 3 queued, then re-enable empty
    step("flush", 1'b0, 1'b0, 0, 0);
    for (int k = 0; k <= 6; k++) step("drop", 1'b1, (k < 4), 20 + k, 5);
    step("drop", 1'b0, 1'b0, 0, 0);
    chk("drop o_if", int'(o_if), 0);
    chk("drop o_ready", int'(o_ready), 1);
    chk("drop o_phase", int'(o_phase), 0);
    for (int k = 0; k <= 5; k++) step("reen", 1'b1, 1'b0, 0, 0);
    chk("reen uf", int'(o_underflow), 1);
    chk("reen phase", int'(o_phase), 0);

    // 6b: async reset while in EMIT with a nonzero o_if held
    step("flush", 1'b0, 1'b0, 0, 0);
    for (int k = 0; k <= 9; k++) step("pre-rst", 1'b1, (k < 2), 9, -9);
    #2 rst_n = 1'b0;
    #1;
    chk("arst o_if", int'(o_if), 0);
    chk("arst o_if_valid", int'(o_if_valid), 0);
    chk("arst o_phase", int'(o_phase), 0);
    chk("arst o_ready", int'(o_ready), 1);
    @(posedge clk); #1;
    chk("arst no pulse", int'(o_if_valid), 0);
    chk("arst o_if hold", int'(o_if), 0);
    i_en = 1'b0; i_valid = 1'b0;
    m_reset();
    #2 rst_n = 1'b1;

    // randomized traffic against the reference model
    pend_v = 1'b0; pend_i = 0; pend_q = 0;
    for (int n = 0; n < 600; n++) begin
      bit acc;
      en_r = ($urandom_range(0, 99) < 97);
      if (!pend_v && $urandom_range(0, 99) < 70) begin
        pend_v = 1'b1;
        pend_i = int'($urandom_range(0, 255)) - 128;
        pend_q = int'($urandom_range(0, 255)) - 128;
      end
      acc = pend_v && en_r && (m_rdy == 1);
      step("rand", en_r, pend_v, pend_i, pend_q);
      if (acc) pend_v = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
